flash_tcm_controller: RTL and testbench
=======================================

# flash_tcm_controller

Avalon-MM slave that turns single CPU read/write commands into timed, strobe-based accesses on the 16-bit parallel flash tristate conduit. Sits directly upstream of the tristate conduit bridge translator, driving its address, read_n, write_n, chipselect_n and split data out/in/outen signals. Arbitrates for the shared pins with a request/grant handshake and applies parameterised setup, strobe and hold cycle counts.

## Interface
- ADDR_W, 27, word address width on both sides
- DATA_W, 16, data width
- SETUP_CYC, 2, cycles address/cs valid before strobe (0..255)
- WAIT_CYC, 6, strobe-low cycles (1..255; 0 is illegal and treated as 1)
- HOLD_CYC, 2, cycles address/cs/data held after strobe (0..255)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- avs_address  in  ADDR_W  word address
- avs_read  in  1  read command
- avs_write  in  1  write command
- avs_writedata  in  DATA_W  write data
- avs_readdata  out  DATA_W  read data, valid when avs_waitrequest low on a read
- avs_waitrequest  out  1  stall; low for exactly one cycle per completed command
- tcm_request  out  1  pin-bus request
- tcm_grant  in  1  pin-bus grant
- tcm_address_out  out  ADDR_W  flash address
- tcm_read_n_out  out  1  output-enable strobe, active low
- tcm_write_n_out  out  1  write strobe, active low
- tcm_chipselect_n_out  out  1  chip select, active low
- tcm_data_out  out  DATA_W  write data to pins
- tcm_data_outen  out  1  pin driver enable
- tcm_data_in  in  DATA_W  read data from pins

## Operation
- States: IDLE, REQ, SETUP, ACCESS, HOLD, DONE.
- IDLE: avs_read or avs_write high → latch address, writedata, direction; go REQ. If both are high, the command is a write.
- REQ: tcm_request=1; remain until tcm_grant=1, then go to SETUP (or ACCESS if SETUP_CYC=0).
- SETUP: chipselect_n=0, address driven, strobes high; for a write, data_out driven and outen=1. SETUP_CYC cycles.
- ACCESS: read_n=0 (read) or write_n=0 (write); WAIT_CYC cycles. On a read, tcm_data_in is registered into avs_readdata on the last ACCESS cycle.
- HOLD: strobes high; cs, address, data_out and outen unchanged; HOLD_CYC cycles. If HOLD_CYC=0, go straight to DONE.
- DONE: chipselect_n=1, outen=0, tcm_request=0, avs_waitrequest=0 for one cycle; return to IDLE.
- tcm_request stays high from REQ through HOLD. A grant drop while the request is held is ignored, because the pin sharer never revokes an active grant.
- One 8-bit down-counter is shared by SETUP, ACCESS and HOLD. It is loaded with N-1 on state entry, and the state exits when the count reaches 0.
- Outputs are registered, so there is no combinational path from avs_* to tcm_*.
- Reset values: tcm_request 0, tcm_chipselect_n_out 1, tcm_read_n_out 1, tcm_write_n_out 1, tcm_address_out 0, tcm_data_out 0, tcm_data_outen 0, avs_readdata 0, avs_waitrequest 1; state IDLE.
- Reset asserted mid-access: all outputs go to their reset values immediately, and the command is dropped with no completion.

## Timing
- The command is sampled at edge E0 while in IDLE, and the master holds it until waitrequest falls.
- With tcm_grant already high, SETUP starts in cycle E0+2. ACCESS spans SETUP_CYC..SETUP_CYC+WAIT_CYC-1 cycles after that, HOLD follows, and DONE (waitrequest=0) falls in cycle E0+2+SETUP_CYC+WAIT_CYC+HOLD_CYC.
- Defaults give waitrequest low 12 cycles after command sampling. Each grant-wait cycle adds 1.
- avs_readdata holds its value until the next read completes.
- A back-to-back command presented in the DONE cycle is consumed; the next command is sampled in the following IDLE cycle.
- Minimum gap between accesses: chipselect_n is high for ≥2 cycles (DONE, IDLE) between consecutive accesses.

## Test plan
- Read, defaults, grant tied high, tcm_data_in=0xBEEF at address 0x123456 → read_n low exactly 6 cycles, cs low 10 cycles, waitrequest low 12 cycles after sampling, readdata=0xBEEF.
- Write of 0xA5C3 to 0x7FFFFFF (max address) → outen=1 and data_out=0xA5C3 across SETUP+ACCESS+HOLD (10 cycles); write_n low 6 cycles; read_n stays 1.
- Grant withheld 5 cycles → tcm_request high and cs high during the wait; completion is delayed by exactly 5 cycles.
- SETUP_CYC=0, WAIT_CYC=1, HOLD_CYC=0 → strobe low 1 cycle, waitrequest low 3 cycles after sampling; WAIT_CYC=0 behaves identically.
- avs_read and avs_write both high with writedata 0x0001 → a write is performed; read_n never asserts.
- Reset pulsed during ACCESS of a write → write_n, cs and outen return high/low immediately. After release, the block is in IDLE with waitrequest=1, and a new read completes normally.

Source files
------------

// File: rtl/flash_tcm_controller.sv
// Purpose: Avalon-MM slave driving a strobe-timed 16-bit parallel flash tristate conduit.
// Latency: waitrequest drops 2+SETUP_CYC+WAIT_CYC+HOLD_CYC cycles after sampling, plus grant-wait cycles.
// Backpressure: avs_waitrequest stays high until the single DONE cycle; pin access waits on tcm_grant.
module flash_tcm_controller #(
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 16,
  parameter int SETUP_CYC = 2,
  parameter int WAIT_CYC  = 6,
  parameter int HOLD_CYC  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic              tcm_request,
  input  logic              tcm_grant,
  output logic [ADDR_W-1:0] tcm_address_out,
  output logic              tcm_read_n_out,
  output logic              tcm_write_n_out,
  output logic              tcm_chipselect_n_out,
  output logic [DATA_W-1:0] tcm_data_out,
  output logic              tcm_data_outen,
  input  logic [DATA_W-1:0] tcm_data_in
);

  // A zero strobe width would never assert the strobe, so it is clamped to one cycle.
  localparam int         WAIT_EFF = (WAIT_CYC < 1) ? 1 : WAIT_CYC;
  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] WAIT_LD  = 8'(WAIT_EFF - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nxt;
  logic              w_latch;
  logic              w_capture;
  logic              w_on_pins;
  logic              r_is_wr;

  logic [DATA_W-1:0] r_readdata;
  logic              r_waitreq;
  logic              r_request;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_n;
  logic              r_wr_n;
  logic              r_cs_n;
  logic [DATA_W-1:0] r_dout;
  logic              r_outen;

  // State register and the shared phase down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: each timed phase loads N-1 on entry and exits when the count hits zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (avs_read || avs_write) begin
          w_latch     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (tcm_grant) begin
          if (SETUP_CYC > 0) begin
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = SETUP_LD;
          end else begin
            w_state_nxt = S_ACCESS;
            w_cnt_nxt   = WAIT_LD;
          end
        end
      end
      S_SETUP: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_ACCESS;
          w_cnt_nxt   = WAIT_LD;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_ACCESS: begin
        if (r_cnt == 8'd0) begin
          w_capture = !r_is_wr;
          if (HOLD_CYC > 0) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = HOLD_LD;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_HOLD: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The pins are owned (cs low) through setup, strobe and hold.
  assign w_on_pins = (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS) ||
                     (w_state_nxt == S_HOLD);

  // Outputs decoded from the next state so every pin and avs output comes straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_wr    <= 1'b0;
      r_readdata <= '0;
      r_waitreq  <= 1'b1;
      r_request  <= 1'b0;
      r_addr     <= '0;
      r_rd_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_cs_n     <= 1'b1;
      r_dout     <= '0;
      r_outen    <= 1'b0;
    end else begin
      if (w_latch) begin
        r_is_wr <= avs_write;
        r_addr  <= avs_address;
        if (avs_write) begin
          r_dout <= avs_writedata;
        end
      end
      if (w_capture) begin
        r_readdata <= tcm_data_in;
      end
      r_waitreq <= (w_state_nxt != S_DONE);
      r_request <= (w_state_nxt == S_REQ) || w_on_pins;
      r_cs_n    <= !w_on_pins;
      r_rd_n    <= !((w_state_nxt == S_ACCESS) && !r_is_wr);
      r_wr_n    <= !((w_state_nxt == S_ACCESS) && r_is_wr);
      r_outen   <= w_on_pins && r_is_wr;
    end
  end

  assign avs_readdata         = r_readdata;
  assign avs_waitrequest      = r_waitreq;
  assign tcm_request          = r_request;
  assign tcm_address_out      = r_addr;
  assign tcm_read_n_out       = r_rd_n;
  assign tcm_write_n_out      = r_wr_n;
  assign tcm_chipselect_n_out = r_cs_n;
  assign tcm_data_out         = r_dout;
  assign tcm_data_outen       = r_outen;

endmodule

// File: tb/tb_flash_tcm_controller.sv
// Purpose: directed bench for flash_tcm_controller with a scoreboard of expected access profiles.
// Latency: each command is observed cycle by cycle until waitrequest drops (bounded).
// Backpressure: grant withholding is driven from the bench; the master holds commands until done.
module tb_flash_tcm_controller;

  logic        clk;
  logic        reset;
  logic [26:0] cmd_addr;
  logic        cmd_rd;
  logic        cmd_wr;
  logic [15:0] cmd_wdata;
  logic        grant;
  logic [15:0] data_in;
  int          sel;

  int vectors;
  int miscompares;

  typedef struct {
    string       tag;
    int          lat;
    int          rdl;
    int          wrl;
    int          csl;
    int          aok;
    int          oen;
    int          reqw;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];

  // Per-DUT output bundles
  logic [15:0] a_rdata, b_rdata, c_rdata;
  logic        a_wait, b_wait, c_wait;
  logic        a_req, b_req, c_req;
  logic [26:0] a_addr, b_addr, c_addr;
  logic        a_rdn, b_rdn, c_rdn;
  logic        a_wrn, b_wrn, c_wrn;
  logic        a_csn, b_csn, c_csn;
  logic [15:0] a_dout, b_dout, c_dout;
  logic        a_oen, b_oen, c_oen;

  flash_tcm_controller u_a (
    .clk(clk), .reset(reset), .avs_address(cmd_addr),
    .avs_read(cmd_rd && sel == 0), .avs_write(cmd_wr && sel == 0),
    .avs_writedata(cmd_wdata), .avs_readdata(a_rdata), .avs_waitrequest(a_wait),
    .tcm_request(a_req), .tcm_grant(grant), .tcm_address_out(a_addr),
    .tcm_read_n_out(a_rdn), .tcm_write_n_out(a_wrn), .tcm_chipselect_n_out(a_csn),
    .tcm_data_out(a_dout), .tcm_data_outen(a_oen), .tcm_data_in(data_in)
  );

  flash_tcm_controller #(.SETUP_CYC(0), .WAIT_CYC(1), .HOLD_CYC(0)) u_b (
    .clk(clk), .reset(reset), .avs_address(cmd_addr),
    .avs_read(cmd_rd && sel == 1), .avs_write(cmd_wr && sel == 1),
    .avs_writedata(cmd_wdata), .avs_readdata(b_rdata), .avs_waitrequest(b_wait),
    .tcm_request(b_req), .tcm_grant(grant), .tcm_address_out(b_addr),
    .tcm_read_n_out(b_rdn), .tcm_write_n_out(b_wrn), .tcm_chipselect_n_out(b_csn),
    .tcm_data_out(b_dout), .tcm_data_outen(b_oen), .tcm_data_in(data_in)
  );

  flash_tcm_controller #(.SETUP_CYC(0), .WAIT_CYC(0), .HOLD_CYC(0)) u_c (
    .clk(clk), .reset(reset), .avs_address(cmd_addr),
    .avs_read(cmd_rd && sel == 2), .avs_write(cmd_wr && sel == 2),
    .avs_writedata(cmd_wdata), .avs_readdata(c_rdata), .avs_waitrequest(c_wait),
    .tcm_request(c_req), .tcm_grant(grant), .tcm_address_out(c_addr),
    .tcm_read_n_out(c_rdn), .tcm_write_n_out(c_wrn), .tcm_chipselect_n_out(c_csn),
    .tcm_data_out(c_dout), .tcm_data_outen(c_oen), .tcm_data_in(data_in)
  );

  // Selected DUT view
  logic [15:0] o_rdata, o_dout;
  logic [26:0] o_addr;
  logic        o_wait, o_req, o_rdn, o_wrn, o_csn, o_oen;

  // Route the DUT under test to the observation signals.
  always_comb begin
    o_rdata = a_rdata; o_wait = a_wait; o_req = a_req; o_addr = a_addr;
    o_rdn = a_rdn; o_wrn = a_wrn; o_csn = a_csn; o_dout = a_dout; o_oen = a_oen;
    if (sel == 1) begin
      o_rdata = b_rdata; o_wait = b_wait; o_req = b_req; o_addr = b_addr;
      o_rdn = b_rdn; o_wrn = b_wrn; o_csn = b_csn; o_dout = b_dout; o_oen = b_oen;
    end else if (sel == 2) begin
      o_rdata = c_rdata; o_wait = c_wait; o_req = c_req; o_addr = c_addr;
      o_rdn = c_rdn; o_wrn = c_wrn; o_csn = c_csn; o_dout = c_dout; o_oen = c_oen;
    end
  end

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic mk_exp(output exp_t e, input string tag, input int lat, rdl, wrl, csl,
                        aok, oen, reqw, input logic [15:0] rdata);
    e.tag = tag; e.lat = lat; e.rdl = rdl; e.wrl = wrl; e.csl = csl;
    e.aok = aok; e.oen = oen; e.reqw = reqw; e.rdata = rdata;
  endtask

  // Issue one command to DUT s, profile its pin activity and score it against the queue head.
  task automatic run_cmd(input int s, input bit rd, input bit wr, input logic [26:0] a,
                         input logic [15:0] d, input logic [15:0] din, input int g, input exp_t e);
    exp_t x;
    int lat, rdl, wrl, csl, aok, oen, reqw;
    logic [15:0] rdata;
    bit done;
    sb.push_back(e);
    lat = 0; rdl = 0; wrl = 0; csl = 0; aok = 0; oen = 0; reqw = 0; rdata = '0; done = 0;
    @(negedge clk);
    sel = s; cmd_rd = rd; cmd_wr = wr; cmd_addr = a; cmd_wdata = d; data_in = din;
    grant = (g == 0);
    @(posedge clk);
    for (int k = 1; k <= 200 && !done; k++) begin
      @(negedge clk);
      if (!o_rdn) rdl++;
      if (!o_wrn) wrl++;
      if (!o_csn) csl++;
      if (!o_csn && o_addr === a) aok++;
      if (o_oen && o_dout === d) oen++;
      if (o_req && o_csn) reqw++;
      if (!o_wait) begin
        lat = k; rdata = o_rdata; done = 1;
      end
      if (k > g) grant = 1'b1;
    end
    cmd_rd = 1'b0; cmd_wr = 1'b0;
    x = sb.pop_front();
    if (!done) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_timeout observed=no_completion expected=completion", x.tag);
    end else begin
      chk({x.tag, "_latency"}, lat, x.lat);
      chk({x.tag, "_read_n_low"}, rdl, x.rdl);
      chk({x.tag, "_write_n_low"}, wrl, x.wrl);
      chk({x.tag, "_cs_low"}, csl, x.csl);
      chk({x.tag, "_addr_ok"}, aok, x.aok);
      chk({x.tag, "_outen_data"}, oen, x.oen);
      chk({x.tag, "_req_wait"}, reqw, x.reqw);
      chk({x.tag, "_readdata"}, int'(rdata), int'(x.rdata));
    end
  endtask

  initial begin
    exp_t e;
    int wl, cl;
    vectors = 0; miscompares = 0;
    sel = 0; cmd_rd = 0; cmd_wr = 0; cmd_addr = '0; cmd_wdata = '0;
    grant = 1'b1; data_in = '0;
    reset = 1'b1;
    #1;
    chk("rst_waitreq", int'(a_wait), 1);
    chk("rst_cs_n", int'(a_csn), 1);
    chk("rst_rd_n", int'(a_rdn), 1);
    chk("rst_wr_n", int'(a_wrn), 1);
    chk("rst_request", int'(a_req), 0);
    chk("rst_outen", int'(a_oen), 0);
    chk("rst_addr", int'(a_addr), 0);
    chk("rst_dout", int'(a_dout), 0);
    chk("rst_rdata", int'(a_rdata), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Default read: 2 setup + 6 strobe + 2 hold
    mk_exp(e, "rd_def", 12, 6, 0, 10, 10, 0, 1, 16'hBEEF);
    run_cmd(0, 1, 0, 27'h0123456, 16'h0000, 16'hBEEF, 0, e);

    // Write at max address; readdata keeps the last read value
    mk_exp(e, "wr_max", 12, 0, 6, 10, 10, 10, 1, 16'hBEEF);
    run_cmd(0, 0, 1, 27'h7FFFFFF, 16'hA5C3, 16'h1111, 0, e);

    // Grant withheld for 5 cycles
    mk_exp(e, "rd_gnt5", 17, 6, 0, 10, 10, 0, 6, 16'h55AA);
    run_cmd(0, 1, 0, 27'h0000042, 16'h0000, 16'h55AA, 5, e);

    // Read and write together resolve to a write
    mk_exp(e, "rdwr", 12, 0, 6, 10, 10, 10, 1, 16'h55AA);
    run_cmd(0, 1, 1, 27'h0000777, 16'h0001, 16'h2222, 0, e);

    // Minimum timing configuration, and the clamped zero-wait configuration
    mk_exp(e, "min_b", 3, 1, 0, 1, 1, 0, 1, 16'h1234);
    run_cmd(1, 1, 0, 27'h0000010, 16'h0000, 16'h1234, 0, e);
    mk_exp(e, "min_c", 3, 1, 0, 1, 1, 0, 1, 16'h4321);
    run_cmd(2, 1, 0, 27'h0000020, 16'h0000, 16'h4321, 0, e);
    mk_exp(e, "min_c_wr", 3, 0, 1, 1, 1, 1, 1, 16'h4321);
    run_cmd(2, 0, 1, 27'h0000030, 16'h9999, 16'h0000, 0, e);

    // Reset pulse in the middle of a write strobe
    @(negedge clk);
    sel = 0; cmd_wr = 1'b1; cmd_addr = 27'h15; cmd_wdata = 16'h3C3C; grant = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    chk("mid_wr_n_before", int'(a_wrn), 0);
    reset = 1'b1;
    #1;
    chk("mid_wr_n", int'(a_wrn), 1);
    chk("mid_cs_n", int'(a_csn), 1);
    chk("mid_outen", int'(a_oen), 0);
    chk("mid_request", int'(a_req), 0);
    chk("mid_waitreq", int'(a_wait), 1);
    chk("mid_rdata", int'(a_rdata), 0);
    cmd_wr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wl = 0; cl = 0;
    repeat (15) begin
      @(negedge clk);
      if (!a_wait) wl++;
      if (!a_csn) cl++;
    end
    chk("post_rst_no_done", wl, 0);
    chk("post_rst_no_cs", cl, 0);

    mk_exp(e, "rd_after_rst", 12, 6, 0, 10, 10, 0, 1, 16'h0F0F);
    run_cmd(0, 1, 0, 27'h0000ABC, 16'h0000, 16'h0F0F, 0, e);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
